// File: rtl/sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// sram_burst_ctrl
//
// Burst access controller mastering a single-port SRAM that has a registered
// read address (mem_rdata shows the word addressed at the previous rising
// edge). One burst command is taken at a time and its beats move over
// valid/ready streams at up to one beat per cycle in either direction.
//
// Parameters:
//   DW  data width, must match the SRAM word width
//   AW  address width, SRAM depth is 2**AW
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cmd_valid/cmd_ready                command handshake (ready only when idle)
//   cmd_write, cmd_addr, cmd_len       1=write/0=read, start address, beats-1
//   wr_valid/wr_ready, wr_data         write beat stream into the controller
//   rd_valid/rd_ready, rd_data, rd_last read beat stream out of the controller
//   busy                               a burst is in progress
//   mem_we, mem_addr, mem_wdata        SRAM request port
//   mem_rdata                          SRAM read data (registered address)
// -----------------------------------------------------------------------------
module sram_burst_ctrl #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [AW-1:0] cmd_len,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [DW-1:0] wr_data,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          busy,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR       = 2'd1,
    RD_PRIME = 2'd2,
    RD       = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW-1:0] remaining, remaining_nxt;

  // Read data is taken straight from the SRAM; it is only meaningful while
  // rd_valid is high.
  assign rd_data = mem_rdata;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      remaining <= '0;
    end else begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      remaining <= remaining_nxt;
    end
  end

  always_comb begin
    // NOTE: every output and next-state variable gets a default first, so no
    // path through the case statement can leave one unassigned (no latches).
    state_nxt     = state;
    ptr_nxt       = ptr;
    remaining_nxt = remaining;
    cmd_ready     = 1'b0;
    wr_ready      = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = ptr;
    mem_wdata     = '0;

    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          ptr_nxt       = cmd_addr;
          remaining_nxt = cmd_len;
          state_nxt     = cmd_write ? WR : RD_PRIME;
        end
      end

      WR: begin
        wr_ready  = 1'b1;
        mem_we    = wr_valid;
        mem_wdata = wr_data;
        if (wr_valid) begin
          ptr_nxt = ptr + 1'b1;
          if (remaining == '0) begin
            state_nxt = IDLE;
          end else begin
            remaining_nxt = remaining - 1'b1;
          end
        end
      end

      // Presents the first address so the SRAM has registered it by the time
      // the first beat is offered.
      RD_PRIME: begin
        state_nxt = RD;
      end

      RD: begin
        rd_valid = 1'b1;
        rd_last  = (remaining == '0);
        if (rd_ready) begin
          // Look ahead on a handshake so the next word is already on
          // mem_rdata next cycle; on a stall the held address keeps rd_data
          // stable.
          mem_addr = ptr + 1'b1;
          ptr_nxt  = ptr + 1'b1;
          if (remaining == '0) begin
            state_nxt = IDLE;
          end else begin
            remaining_nxt = remaining - 1'b1;
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sram_burst_ctrl
//
// Directed bench for sram_burst_ctrl with a behavioural 16x16 SRAM that has a
// registered read address. Expected SRAM writes and expected read beats are
// queued when stimulus is driven and popped when the DUT produces them; a
// reference copy of memory contents supplies read expectations.
// -----------------------------------------------------------------------------
module tb_sram_burst_ctrl;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [AW-1:0] cmd_len = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_last;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  always #5 clk = ~clk;

  sram_burst_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Behavioural SRAM: write on edge, address registered for read.
  logic [DW-1:0] sram [DEPTH];
  logic [AW-1:0] sram_addr_q = '0;
  logic          sram_init_done = 1'b0;

  always @(posedge clk) begin
    if (!sram_init_done) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= DW'(16'h5A00 + i);
      sram_init_done <= 1'b1;
    end else if (mem_we) begin
      sram[mem_addr] <= mem_wdata;
    end
    sram_addr_q <= mem_addr;
  end

  assign mem_rdata = sram[sram_addr_q];

  // Scoreboard
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } rd_exp_t;

  wr_exp_t       wq[$];
  rd_exp_t       rq[$];
  logic [DW-1:0] ref_mem [DEPTH];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers a command and waits (bounded) for the handshake; returns #1 after
  // the handshake edge with cmd_valid dropped.
  task automatic issue_cmd(input logic w, input logic [AW-1:0] a, input logic [AW-1:0] l);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("cmd_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // One write beat: queue the expected SRAM write, then compare what the DUT
  // presents on the SRAM port.
  task automatic wr_one(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_exp_t e;
    wr_valid = 1'b1;
    wr_data  = d;
    wq.push_back('{addr: a, data: d});
    @(negedge clk);
    check("wr_ready", 32'(wr_ready), 32'd1);
    check("wr_cmd_ready_low", 32'(cmd_ready), 32'd0);
    check("wr_we", 32'(mem_we), 32'd1);
    if (mem_we && wq.size() > 0) begin
      e = wq.pop_front();
      check("wr_addr", 32'(mem_addr), 32'(e.addr));
      check("wr_data", 32'(mem_wdata), 32'(e.data));
      ref_mem[e.addr] = e.data;
    end
    @(posedge clk); #1;
  endtask

  // Whole write burst; data = base + step*i. One idle wr_valid cycle is
  // inserted before beat stall_at (negative for none).
  task automatic wr_beats(input logic [AW-1:0] a, input int len,
                          input logic [DW-1:0] base, input logic [DW-1:0] step,
                          input int stall_at);
    logic [AW-1:0] addr;
    for (int i = 0; i <= len; i++) begin
      if (i == stall_at) begin
        wr_valid = 1'b0;
        @(negedge clk);
        check("wr_stall_we", 32'(mem_we), 32'd0);
        check("wr_stall_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
      end
      addr = a + AW'(i);
      wr_one(addr, DW'(32'(base) + 32'(step) * i));
    end
    wr_valid = 1'b0;
    wr_data  = '0;
    @(negedge clk);
    check("wr_end_busy", 32'(busy), 32'd0);
    check("wr_end_cmd_ready", 32'(cmd_ready), 32'd1);
    check("wr_end_we", 32'(mem_we), 32'd0);
  endtask

  // Read burst, called #1 after the command handshake edge. rd_ready follows
  // pat[k%4] on successive cycles.
  task automatic rd_beats(input logic [AW-1:0] a, input int len, input logic [3:0] pat);
    logic [AW-1:0] addr;
    int k;
    for (int i = 0; i <= len; i++) begin
      addr = a + AW'(i);
      rq.push_back('{data: ref_mem[addr], last: (i == len)});
    end
    @(negedge clk);
    check("rd_prime_busy", 32'(busy), 32'd1);
    check("rd_prime_valid", 32'(rd_valid), 32'd0);
    check("rd_prime_addr", 32'(mem_addr), 32'(a));
    check("rd_prime_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clk); #1;
    k = 0;
    while (rq.size() > 0 && k < 200) begin
      rd_ready = pat[k % 4];
      @(negedge clk);
      check("rd_valid", 32'(rd_valid), 32'd1);
      check("rd_data", 32'(rd_data), 32'(rq[0].data));
      check("rd_last", 32'(rd_last), 32'(rq[0].last));
      if (rd_ready) void'(rq.pop_front());
      @(posedge clk); #1;
      k++;
    end
    check("rd_all_beats", 32'(rq.size()), 32'd0);
    rq.delete();
    rd_ready = 1'b0;
    @(negedge clk);
    check("rd_end_busy", 32'(busy), 32'd0);
    check("rd_end_valid", 32'(rd_valid), 32'd0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = DW'(16'h5A00 + i);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_last", 32'(rd_last), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);

    // Write 0xA000..0xA003 to 2..5, then read back at full rate
    issue_cmd(1'b1, 4'd2, 4'd3);
    wr_beats(4'd2, 3, 16'hA000, 16'h0001, -1);
    issue_cmd(1'b0, 4'd2, 4'd3);
    rd_beats(4'd2, 3, 4'b1111);

    // Same read with rd_ready 1,0,0,1,...
    issue_cmd(1'b0, 4'd2, 4'd3);
    rd_beats(4'd2, 3, 4'b1001);

    // Wrap across 15 -> 0, with a wr_valid stall mid-burst
    issue_cmd(1'b1, 4'd14, 4'd3);
    wr_beats(4'd14, 3, 16'h1111, 16'h1111, 2);
    issue_cmd(1'b0, 4'd14, 4'd3);
    rd_beats(4'd14, 3, 4'b1111);

    // Second command held during a burst: accepted the cycle after it ends
    issue_cmd(1'b1, 4'd6, 4'd1);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 4'd6;
    cmd_len   = 4'd1;
    wr_beats(4'd6, 1, 16'hB000, 16'h0001, -1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rd_beats(4'd6, 1, 4'b1111);

    // Full-depth burst from a mid address covers every location once
    issue_cmd(1'b1, 4'd9, 4'd15);
    wr_beats(4'd9, 15, 16'hD000, 16'h0001, -1);
    issue_cmd(1'b0, 4'd9, 4'd15);
    rd_beats(4'd9, 15, 4'b1011);

    // Reset during beat 2 of an 8-beat write at address 8
    issue_cmd(1'b1, 4'd8, 4'd7);
    wr_one(4'd8, 16'hC000);
    wr_one(4'd9, 16'hC001);
    wr_valid = 1'b1;
    wr_data  = 16'hC002;
    rst_n    = 1'b0;
    @(negedge clk);
    check("abort_mem_we", 32'(mem_we), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_wr_ready", 32'(wr_ready), 32'd0);
    check("abort_mem_addr", 32'(mem_addr), 32'd0);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wr_data  = '0;
    rst_n    = 1'b1;
    @(negedge clk);
    issue_cmd(1'b0, 4'd8, 4'd7);
    rd_beats(4'd8, 7, 4'b1111);

    check("wr_queue_empty", 32'(wq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
